// File: rtl/upd7800_clkgen_pkg.sv
// Shared types and defaults for the uPD7800 two-phase clock generator.
// Quarter-state encoding is shared with the core's microcode sequencer.
package upd7800_clkgen_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } e_quarter;

    localparam int unsigned QLEN_DEFAULT       = 2;
    localparam int unsigned RST_STATES_DEFAULT = 4;
    localparam int unsigned TCNT_W             = 16;

    function automatic e_quarter next_quarter(input e_quarter q);
        e_quarter n;
        case (q)
            Q0:      n = Q1;
            Q1:      n = Q2;
            Q2:      n = Q3;
            default: n = Q0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/upd7800_clkgen_if.sv
// Clock-enable / phase-strobe bundle between the clock generator and the uPD7800 core.
interface upd7800_clkgen_if;
    import upd7800_clkgen_pkg::*;

    logic              CE;
    logic              HOLD;
    logic              CP1_POSEDGE;
    logic              CP1_NEGEDGE;
    logic              CP2_POSEDGE;
    logic              CP2_NEGEDGE;
    logic              CP1;
    logic              CP2;
    logic              RESETB;
    logic [TCNT_W-1:0] TCNT;

    modport master (
        input  CE, HOLD,
        output CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE,
        output CP1, CP2, RESETB, TCNT
    );

    modport slave (
        output CE, HOLD,
        input  CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE,
        input  CP1, CP2, RESETB, TCNT
    );

endinterface

// File: rtl/upd7800_rststretch.sv
// Holds the CPU reset low for RST_STATES T-states, releasing it together
// with a CP2 falling-edge strobe so the core sees a clean deassertion.
module upd7800_rststretch
    import upd7800_clkgen_pkg::*;
#(
    parameter int unsigned RST_STATES = RST_STATES_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic enter_q3,
    output logic RESETB
);

    logic [7:0] cnt_q, cnt_d;
    logic       resetb_q, resetb_d;

    always_comb begin
        cnt_d    = cnt_q;
        resetb_d = resetb_q;
        if (enter_q3 && !resetb_q) begin
            cnt_d = cnt_q - 8'd1;
            // Release on the entry that takes the count to zero.
            if (cnt_q <= 8'd1) begin
                resetb_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q    <= 8'(RST_STATES);
            resetb_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            resetb_q <= resetb_d;
        end
    end

    assign RESETB = resetb_q;

endmodule

// File: rtl/upd7800_clkgen.sv
// Two-phase non-overlapping clock-enable sequencer for the uPD7800 core:
// Q0..Q3 quarter states, CE gating, HOLD stretching in Q3, T-state counter.
module upd7800_clkgen
    import upd7800_clkgen_pkg::*;
#(
    parameter int unsigned QLEN       = QLEN_DEFAULT,
    parameter int unsigned RST_STATES = RST_STATES_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    upd7800_clkgen_if.master  bus
);

    localparam int unsigned     QcntW   = (QLEN > 1) ? $clog2(QLEN) : 1;
    localparam logic [QcntW-1:0] QcntMax = QcntW'(QLEN - 1);

    e_quarter          quarter_q, quarter_d;
    logic [QcntW-1:0]  qcnt_q, qcnt_d;
    // {CP1 rise, CP1 fall, CP2 rise, CP2 fall}
    logic [3:0]        strobe_q, strobe_d;
    logic              cp1_q, cp1_d;
    logic              cp2_q, cp2_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              enter_q3;

    always_comb begin
        quarter_d = quarter_q;
        qcnt_d    = qcnt_q;
        strobe_d  = 4'b0000;
        tcnt_d    = tcnt_q;
        enter_q3  = 1'b0;
        if (bus.CE) begin
            if (qcnt_q != QcntMax) begin
                qcnt_d = qcnt_q + 1'b1;
            end else if (quarter_q == Q3 && bus.HOLD) begin
                // Stretch: sit at the end of Q3 ready to leave on the first free cycle.
                qcnt_d = QcntMax;
            end else begin
                qcnt_d    = '0;
                quarter_d = next_quarter(quarter_q);
                unique case (quarter_d)
                    Q0: begin
                        strobe_d = 4'b1000;
                        tcnt_d   = tcnt_q + 16'd1;
                    end
                    Q1: strobe_d = 4'b0100;
                    Q2: strobe_d = 4'b0010;
                    Q3: begin
                        strobe_d = 4'b0001;
                        enter_q3 = 1'b1;
                    end
                endcase
            end
        end
        cp1_d = (quarter_d == Q0);
        cp2_d = (quarter_d == Q2);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            quarter_q <= Q3;
            qcnt_q    <= '0;
            strobe_q  <= 4'b0000;
            cp1_q     <= 1'b0;
            cp2_q     <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            quarter_q <= quarter_d;
            qcnt_q    <= qcnt_d;
            strobe_q  <= strobe_d;
            cp1_q     <= cp1_d;
            cp2_q     <= cp2_d;
            tcnt_q    <= tcnt_d;
        end
    end

    upd7800_rststretch #(
        .RST_STATES (RST_STATES)
    ) u_rststretch (
        .CLK      (CLK),
        .RESET    (RESET),
        .enter_q3 (enter_q3),
        .RESETB   (bus.RESETB)
    );

    assign bus.CP1_POSEDGE = strobe_q[3];
    assign bus.CP1_NEGEDGE = strobe_q[2];
    assign bus.CP2_POSEDGE = strobe_q[1];
    assign bus.CP2_NEGEDGE = strobe_q[0];
    assign bus.CP1         = cp1_q;
    assign bus.CP2         = cp2_q;
    assign bus.TCNT        = tcnt_q;

endmodule
